cache_controller: RTL
=====================

Name: cache_controller

Overview:
Sequences the direct-mapped data cache against the external SRAM for the MIPS MEM stage. Owns the valid/tag/data line array and the hit/miss decision, and runs the SRAM handshake on read misses and on every write (write-through, write-allocate; one word per line). Drives a ready signal that the hazard unit uses to freeze the pipeline, and keeps hit/miss performance counters.

Parameters:
data_lenght, 65536, words of SRAM address space; address width = $clog2(data_lenght) = 16
data_width, 32, data word width
cache_lenght, 16, number of lines; index = address[$clog2(cache_lenght)-1:0]; tag = remaining upper address bits (12 by default)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
mem_read  input  1  MEM-stage load request, held until ready=1
mem_write  input  1  MEM-stage store request, held until ready=1
address  input  16  word address
write_data  input  data_width  store data
read_data  output  data_width  load data, valid when ready=1 and mem_read=1
ready  output  1  1 = request complete or none pending; 0 = freeze pipeline
sram_read  output  1  SRAM read strobe
sram_write  output  1  SRAM write strobe
sram_address  output  16  latched request address
sram_writedata  output  data_width  latched store data
sram_readdata  input  data_width  SRAM read data, valid when sram_ready=1
sram_ready  input  1  SRAM completes the current strobe this cycle
hit_count  output  16  read hits, saturating
miss_count  output  16  read misses, saturating

Behaviour:
- Reset (rst=0, asynchronous): all valid bits 0; state IDLE; sram_read=0, sram_write=0; sram_address=0; sram_writedata=0; counters 0. Data and tag contents are don't-care.
- States: IDLE, RD_MISS, WR_THRU, RESP.
- IDLE:
  - ready = !(mem_write | (mem_read & !hit)); combinational.
  - hit = valid[index] & (tag[index] == address tag).
  - read_data = line data on a hit. A read hit completes in 0 wait cycles.
  - mem_write (priority over mem_read if both asserted): latch address and write_data; write the line {valid=1, tag, data} at this edge; go to WR_THRU.
  - mem_read & hit: hit_count+1; stay in IDLE.
  - mem_read & !hit: latch address; miss_count+1; go to RD_MISS.
- RD_MISS:
  - sram_read=1 and ready=0 until sram_ready is sampled 1.
  - On that edge: capture sram_readdata; fill the line {1, tag, data}; go to RESP.
- WR_THRU:
  - sram_write=1 and ready=0 until sram_ready is sampled 1, then go to RESP.
- RESP:
  - One cycle: ready=1, strobes 0, read_data = captured SRAM word (load) or don't-care (store). Always return to IDLE.
  - A request still high in RESP is consumed by the pipeline, not re-evaluated; a new request is evaluated in IDLE on the next cycle.
- sram_read and sram_write are registered state decodes. They are never both 1, and never 1 in IDLE or RESP.
- Counters: each saturates at 16'hFFFF with no wrap. Writes are counted in neither counter.
- sram_ready is ignored in IDLE and RESP.
- The same index with a different tag evicts silently. No dirty state exists because the cache is write-through.
- Reset mid-RD_MISS or mid-WR_THRU: strobes drop immediately and the state returns to IDLE; the pending fill is discarded and the line stays invalid.
- Stall length = SRAM latency + 1 cycle (RESP) on a miss or write. A hit adds no stall.

Test Plan:
- Reset then read 16'h0013, with the SRAM returning 32'hDEADBEEF after 3 cycles -> sram_read high for 3 cycles, ready=0 for 4 cycles, RESP read_data=32'hDEADBEEF, miss_count=1.
- Read 16'h0013 again -> ready=1 the same cycle, read_data=32'hDEADBEEF, no sram_read, hit_count=1.
- Write 16'h0023 with 32'h12345678 (same index, new tag) -> sram_write held until sram_ready with sram_address=16'h0023 and sram_writedata=32'h12345678; the next read of 0x0023 hits with 32'h12345678, and a read of 0x0013 misses.
- mem_read and mem_write both asserted at 16'h0005 -> write path taken (sram_write only), counters unchanged.
- Deassert rst for one cycle while in RD_MISS -> sram_read=0 immediately, ready=1 in IDLE, and a read of the same address misses again.
- Force hit_count to 16'hFFFF via 65535 hits and then one more hit -> hit_count stays 16'hFFFF.

Source files
------------

// File: rtl/cache_controller.sv
// cache_controller: direct-mapped write-through/write-allocate data cache sequencing
// the external SRAM for the MEM stage, with pipeline ready and hit/miss counters.
module cache_controller #(
    parameter int data_lenght  = 65536,
    parameter int data_width   = 32,
    parameter int cache_lenght = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            mem_read,
    input  logic                            mem_write,
    input  logic [$clog2(data_lenght)-1:0]  address,
    input  logic [data_width-1:0]           write_data,
    output logic [data_width-1:0]           read_data,
    output logic                            ready,
    output logic                            sram_read,
    output logic                            sram_write,
    output logic [$clog2(data_lenght)-1:0]  sram_address,
    output logic [data_width-1:0]           sram_writedata,
    input  logic [data_width-1:0]           sram_readdata,
    input  logic                            sram_ready,
    output logic [15:0]                     hit_count,
    output logic [15:0]                     miss_count
);
    localparam int AW = $clog2(data_lenght);
    localparam int IW = $clog2(cache_lenght);
    localparam int TW = AW - IW;

    typedef enum logic [1:0] {IDLE, RD_MISS, WR_THRU, RESP} state_t;

    state_t                  state_q, state_d;
    logic [cache_lenght-1:0] valid_q;
    logic [TW-1:0]           tag_q  [cache_lenght];
    logic [data_width-1:0]   data_q [cache_lenght];
    logic [AW-1:0]           addr_q;
    logic [data_width-1:0]   wdata_q, rdata_q;
    logic [15:0]             hit_count_q, miss_count_q;

    logic [IW-1:0]         req_idx, fill_idx;
    logic [TW-1:0]         req_tag, fill_tag;
    logic [data_width-1:0] fill_data;
    logic                  hit, idle, start_wr, rd_hit, rd_miss, fill_en;

    assign req_idx  = address[IW-1:0];
    assign req_tag  = address[AW-1:IW];
    assign hit      = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign idle     = (state_q == IDLE);
    assign start_wr = idle && mem_write;
    assign rd_hit   = idle && !mem_write && mem_read && hit;
    assign rd_miss  = idle && !mem_write && mem_read && !hit;

    // A line is written either when a store is accepted or when the SRAM returns a fill.
    assign fill_en   = start_wr || (state_q == RD_MISS && sram_ready);
    assign fill_idx  = start_wr ? req_idx : addr_q[IW-1:0];
    assign fill_tag  = start_wr ? req_tag : addr_q[AW-1:IW];
    assign fill_data = start_wr ? write_data : sram_readdata;

    always_comb begin
        state_d   = state_q;
        ready     = 1'b0;
        read_data = rdata_q;
        case (state_q)
            IDLE: begin
                state_d   = mem_write ? WR_THRU : (mem_read && !hit) ? RD_MISS : IDLE;
                ready     = !(mem_write || (mem_read && !hit));
                read_data = data_q[req_idx];
            end
            RD_MISS: state_d = sram_ready ? RESP : RD_MISS;
            WR_THRU: state_d = sram_ready ? RESP : WR_THRU;
            default: begin
                state_d = IDLE;
                ready   = 1'b1;
            end
        endcase
    end

    assign sram_read      = (state_q == RD_MISS);
    assign sram_write     = (state_q == WR_THRU);
    assign sram_address   = addr_q;
    assign sram_writedata = wdata_q;
    assign hit_count      = hit_count_q;
    assign miss_count     = miss_count_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            valid_q      <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            state_q <= state_d;
            if (start_wr || rd_miss) addr_q <= address;
            if (start_wr) wdata_q <= write_data;
            if (state_q == RD_MISS && sram_ready) rdata_q <= sram_readdata;
            if (fill_en) valid_q[fill_idx] <= 1'b1;
            if (rd_hit && hit_count_q != 16'hFFFF) hit_count_q <= hit_count_q + 16'd1;
            if (rd_miss && miss_count_q != 16'hFFFF) miss_count_q <= miss_count_q + 16'd1;
        end
    end

    // Tag and data need no reset; valid_q alone decides whether they mean anything.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_q[fill_idx]  <= fill_tag;
            data_q[fill_idx] <= fill_data;
        end
    end
endmodule
